// File: rtl/mips_cache_pkg.sv
// Shared types for the MIPS cache/memory slice: arbiter states, read owner, Avalon widths.
package mips_cache_pkg;

    localparam int AV_ADDR_W = 32;
    localparam int AV_DATA_W = 32;
    localparam int AV_BE_W   = 4;

    typedef enum logic [1:0] {IDLE, WRITE, RD_REQ, RD_DATA} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/mips_cache_avalon_arbiter.sv
// Shares one Avalon-MM master between icache/dcache read misses and the write buffer,
// one transfer at a time, reads first with bounded write starvation.
module mips_cache_avalon_arbiter
    import mips_cache_pkg::*;
#(
    parameter int MAX_READS          = 4,
    parameter int DRAIN_BEFORE_DREAD = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ic_read,
    input  logic [AV_ADDR_W-1:0] ic_addr,
    output logic [AV_DATA_W-1:0] ic_readdata,
    output logic                 ic_readvalid,
    input  logic                 dc_read,
    input  logic [AV_ADDR_W-1:0] dc_addr,
    output logic [AV_DATA_W-1:0] dc_readdata,
    output logic                 dc_readvalid,
    input  logic                 wb_write,
    input  logic [AV_ADDR_W-1:0] wb_addr,
    input  logic [AV_DATA_W-1:0] wb_writedata,
    input  logic [AV_BE_W-1:0]   wb_byteenable,
    input  logic                 wb_empty,
    input  logic                 wb_full,
    output logic                 wb_active,
    output logic                 wb_waitrequest,
    output logic [AV_ADDR_W-1:0] avm_address,
    output logic                 avm_read,
    output logic                 avm_write,
    output logic [AV_DATA_W-1:0] avm_writedata,
    output logic [AV_BE_W-1:0]   avm_byteenable,
    input  logic                 avm_waitrequest,
    input  logic [AV_DATA_W-1:0] avm_readdata
);

    localparam int CNT_W = $clog2(MAX_READS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_READS);

    arb_state_t       state, state_nx;
    owner_t           owner, owner_nx;
    logic [CNT_W-1:0] starve_cnt, starve_nx;
    logic             dread_ok;

    // With draining enabled a data read waits until no older write can alias it.
    assign dread_ok = (DRAIN_BEFORE_DREAD == 0) || wb_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            starve_cnt <= starve_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        owner_nx       = owner;
        starve_nx      = starve_cnt;
        avm_address    = '0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_writedata  = '0;
        avm_byteenable = '0;
        wb_active      = 1'b0;
        wb_waitrequest = 1'b1;
        ic_readvalid   = 1'b0;
        dc_readvalid   = 1'b0;
        ic_readdata    = '0;
        dc_readdata    = '0;

        case (state)
            IDLE: begin
                if (wb_full) begin
                    state_nx = WRITE;
                end else if (starve_cnt == CNT_MAX && !wb_empty) begin
                    state_nx = WRITE;
                end else if (dc_read && dread_ok) begin
                    state_nx = RD_REQ;
                    owner_nx = OWN_D;
                end else if (ic_read) begin
                    state_nx = RD_REQ;
                    owner_nx = OWN_I;
                end else if (!wb_empty) begin
                    state_nx = WRITE;
                end
            end

            WRITE: begin
                wb_active      = 1'b1;
                avm_write      = wb_write;
                avm_address    = wb_addr;
                avm_writedata  = wb_writedata;
                avm_byteenable = wb_byteenable;
                // Pop is only allowed when a word is actually on the bus.
                wb_waitrequest = wb_write ? avm_waitrequest : 1'b1;
                if (wb_write && !avm_waitrequest) begin
                    state_nx  = IDLE;
                    starve_nx = '0;
                end else if (!wb_write && wb_empty) begin
                    state_nx = IDLE;
                end
            end

            RD_REQ: begin
                avm_read       = 1'b1;
                avm_address    = (owner == OWN_D) ? dc_addr : ic_addr;
                avm_byteenable = '1;
                if (!avm_waitrequest) begin
                    state_nx = RD_DATA;
                    if (!wb_empty && starve_cnt != CNT_MAX)
                        starve_nx = starve_cnt + 1'b1;
                end
            end

            RD_DATA: begin
                if (owner == OWN_D) begin
                    dc_readvalid = 1'b1;
                    dc_readdata  = avm_readdata;
                end else begin
                    ic_readvalid = 1'b1;
                    ic_readdata  = avm_readdata;
                end
                state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule
